// File: rtl/spi_pkg.sv
// spi_pkg: shared state type, SPI mode encodings and sizing helper for the SPI master.
package spi_pkg;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

   // SPI modes encoded as {CKP, CPH}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Width needed to index n items, never less than one bit
   function automatic int clog2_min1(input int n);
      int r;
      if (n <= 2) begin
         r = 1;
      end else begin
         r = $clog2(n);
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer and SCK phase generator. One tick every
// i_div+1 cycles while active; SCK edges are produced on ticks at the end of
// SETUP and inside XFER until 2*DATA_W edges have been issued.
module spi_clk_gen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_active,
   input  logic             i_setup,
   input  logic             i_xfer,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick,
   output logic             o_lead_edge,
   output logic             o_trail_edge,
   output logic             o_last_edge,
   output logic             o_xfer_done,
   output logic             o_sck_tog
);
   localparam int                EDGE_W    = $clog2(2 * DATA_W) + 1;
   localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * DATA_W);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   // One extra bit so an all-ones divider can never wrap the counter
   logic [DIV_W:0]      r_half_cnt;
   logic [EDGE_W-1:0]   r_edge_cnt;
   logic                r_tog;
   logic                w_tick;
   logic                w_edge;

   assign w_tick = i_active && (r_half_cnt == {1'b0, i_div});
   assign w_edge = w_tick && (i_setup || (i_xfer && (r_edge_cnt != EDGE_END)));

   // Half-period counter: restarts on every tick and whenever the master is idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half_cnt <= '0;
      end else if (!i_active || w_tick) begin
         r_half_cnt <= '0;
      end else begin
         r_half_cnt <= r_half_cnt + (DIV_W + 1)'(1);
      end
   end

   // Edge counter and SCK phase: each produced edge toggles SCK away from/back to idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge_cnt <= '0;
         r_tog      <= 1'b0;
      end else if (!i_active) begin
         r_edge_cnt <= '0;
         r_tog      <= 1'b0;
      end else if (w_edge) begin
         r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
         r_tog      <= ~r_tog;
      end else begin
         r_edge_cnt <= r_edge_cnt;
         r_tog      <= r_tog;
      end
   end

   // Even edge counts leave SCK idle, so the next edge is a leading one
   assign o_tick       = w_tick;
   assign o_lead_edge  = w_edge && !r_edge_cnt[0];
   assign o_trail_edge = w_edge && r_edge_cnt[0];
   assign o_last_edge  = (r_edge_cnt == EDGE_LAST);
   assign o_xfer_done  = w_tick && i_xfer && (r_edge_cnt == EDGE_END);
   assign o_sck_tog    = r_tog;

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with start/busy/done
// handshake, per-transfer shadowed configuration and active-low chip selects.
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8,
   parameter int CS_W   = clog2_min1(NUM_CS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              LSB_FIRST,
   input  logic [DIV_W-1:0]  CLK_DIV,
   input  logic              start,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [DATA_W-1:0] data_in,
   input  logic              MISO,
   output logic              busy,
   output logic              done,
   output logic [NUM_CS-1:0] CS,
   output logic              SCK,
   output logic              MOSI,
   output logic [DATA_W-1:0] data_out
);
   localparam logic [CS_W:0] NUM_CS_L = (CS_W + 1)'(NUM_CS);

   spi_state_e          r_state;
   spi_state_e          w_state_nxt;
   logic                r_ckp;
   logic                r_cph;
   logic                r_lsb;
   logic [DIV_W-1:0]    r_div;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic [DATA_W-1:0]   r_data_out;
   logic [NUM_CS-1:0]   r_cs;
   logic                r_mosi;
   logic                r_busy;
   logic                r_done;
   logic                w_cs_ok;
   logic                w_accept;
   logic                w_finish;
   logic                w_active;
   logic                w_setup;
   logic                w_xfer;
   logic                w_tick;
   logic                w_lead;
   logic                w_trail;
   logic                w_last;
   logic                w_xfer_done;
   logic                w_sck_tog;
   logic                w_sample;
   logic                w_advance;

   assign w_cs_ok  = ({1'b0, cs_sel} < NUM_CS_L);
   assign w_active = (r_state != IDLE);
   assign w_setup  = (r_state == SETUP);
   assign w_xfer   = (r_state == XFER);

   spi_clk_gen #(
      .DATA_W (DATA_W),
      .DIV_W  (DIV_W)
   ) u_clk_gen (
      .clk          (CLK),
      .rst_n        (RESET),
      .i_active     (w_active),
      .i_setup      (w_setup),
      .i_xfer       (w_xfer),
      .i_div        (r_div),
      .o_tick       (w_tick),
      .o_lead_edge  (w_lead),
      .o_trail_edge (w_trail),
      .o_last_edge  (w_last),
      .o_xfer_done  (w_xfer_done),
      .o_sck_tog    (w_sck_tog)
   );

   // State register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE -> SETUP -> XFER -> HOLD -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && w_cs_ok) begin
               w_state_nxt = SETUP;
               w_accept    = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETUP: begin
            if (w_tick) begin
               w_state_nxt = XFER;
            end else begin
               w_state_nxt = SETUP;
            end
         end
         XFER: begin
            if (w_xfer_done) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = XFER;
            end
         end
         HOLD: begin
            if (w_tick) begin
               w_state_nxt = IDLE;
               w_finish    = 1'b1;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Select which SCK edge samples MISO and which advances MOSI for the latched mode
   always_comb begin
      w_sample  = 1'b0;
      w_advance = 1'b0;
      case ({r_ckp, r_cph})
         MODE0, MODE2: begin
            w_sample  = w_lead;
            w_advance = w_trail && !w_last;
         end
         MODE1, MODE3: begin
            w_sample  = w_trail;
            w_advance = w_lead;
         end
         default: begin
            w_sample  = 1'b0;
            w_advance = 1'b0;
         end
      endcase
   end

   // Datapath: shadow config, shift registers, chip selects and handshake outputs
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_ckp      <= 1'b0;
         r_cph      <= 1'b0;
         r_lsb      <= 1'b0;
         r_div      <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_data_out <= '0;
         r_cs       <= '1;
         r_mosi     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= w_finish;
         if (w_accept) begin
            r_ckp <= CKP;
            r_cph <= CPH;
            r_lsb <= LSB_FIRST;
            r_div <= CLK_DIV;
            r_cs  <= ~(NUM_CS'(1) << cs_sel);
            r_rx  <= '0;
            if (!CPH) begin
               // Leading-edge sampling needs the first bit on the wire during SETUP
               r_mosi <= LSB_FIRST ? data_in[0] : data_in[DATA_W-1];
               r_tx   <= LSB_FIRST ? {1'b0, data_in[DATA_W-1:1]} : {data_in[DATA_W-2:0], 1'b0};
            end else begin
               r_mosi <= 1'b0;
               r_tx   <= data_in;
            end
         end else if (w_finish) begin
            r_cs       <= '1;
            r_mosi     <= 1'b0;
            r_data_out <= r_rx;
         end else begin
            if (w_advance) begin
               r_mosi <= r_lsb ? r_tx[0] : r_tx[DATA_W-1];
               r_tx   <= r_lsb ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
            end else begin
               r_mosi <= r_mosi;
               r_tx   <= r_tx;
            end
            if (w_sample) begin
               r_rx <= r_lsb ? {MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], MISO};
            end else begin
               r_rx <= r_rx;
            end
         end
      end
   end

   // While idle SCK follows the live CKP input; otherwise the latched polarity
   assign SCK      = (r_state == IDLE) ? CKP : (r_ckp ^ w_sck_tog);
   assign busy     = r_busy;
   assign done     = r_done;
   assign CS       = r_cs;
   assign MOSI     = r_mosi;
   assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed vectors with a done-driven scoreboard monitor.
`timescale 1ns/1ps
module tb_spi_master_param;
   import spi_pkg::*;

   localparam int DATA_W = 8;
   localparam int NUM_CS = 4;
   localparam int DIV_W  = 8;
   localparam int CS_W   = 3;

   logic              CLK = 1'b0;
   logic              RESET = 1'b0;
   logic              CKP = 1'b0;
   logic              CPH = 1'b0;
   logic              LSB_FIRST = 1'b0;
   logic [DIV_W-1:0]  CLK_DIV = '0;
   logic              start = 1'b0;
   logic [CS_W-1:0]   cs_sel = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              MISO;
   logic              busy;
   logic              done;
   logic [NUM_CS-1:0] CS;
   logic              SCK;
   logic              MOSI;
   logic [DATA_W-1:0] data_out;

   logic miso_loop = 1'b1;
   logic miso_tie  = 1'b0;
   assign MISO = miso_loop ? MOSI : miso_tie;

   spi_master_param #(
      .DATA_W (DATA_W),
      .NUM_CS (NUM_CS),
      .DIV_W  (DIV_W),
      .CS_W   (CS_W)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .CKP       (CKP),
      .CPH       (CPH),
      .LSB_FIRST (LSB_FIRST),
      .CLK_DIV   (CLK_DIV),
      .start     (start),
      .cs_sel    (cs_sel),
      .data_in   (data_in),
      .MISO      (MISO),
      .busy      (busy),
      .done      (done),
      .CS        (CS),
      .SCK       (SCK),
      .MOSI      (MOSI),
      .data_out  (data_out)
   );

   // System clock
   always #5 CLK = ~CLK;

   int cyc = 0;
   // Cycle counter: value after posedge n is n
   always @(posedge CLK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int data;
      int cyc;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard monitor: each done pulse is matched against the oldest expectation
   always @(negedge CLK) begin
      if (RESET && done) begin
         check("done_expected", int'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("done_data", int'(data_out), mon_e.data);
            check("done_cycle", cyc, mon_e.cyc);
            check("busy_low_at_done", int'(busy), 0);
         end
      end
   end

   // Measurement results of the last measure() call
   int         m_cs_low, m_other_low, m_rise, m_fall, m_first_rise, m_last_rise, m_busy, m_done;
   logic [7:0] m_mosi_bits;

   task automatic pulse_start(input logic [CS_W-1:0] sel, input logic [7:0] din, output int k);
      @(negedge CLK);
      cs_sel  = sel;
      data_in = din;
      start   = 1'b1;
      k       = cyc + 1;
      @(negedge CLK);
      start   = 1'b0;
   endtask

   task automatic issue(input logic ckp, input logic cph, input logic lsb, input logic [7:0] div,
                        input logic [CS_W-1:0] sel, input logic [7:0] din, output int k);
      @(negedge CLK);
      CKP       = ckp;
      CPH       = cph;
      LSB_FIRST = lsb;
      CLK_DIV   = div;
      pulse_start(sel, din, k);
   endtask

   // Samples n negedges; inject_kind 1 = stray start, 2 = flip config inputs
   task automatic measure(input int n, input int sel, input int inject_at, input int inject_kind);
      logic prev;
      m_cs_low = 0; m_other_low = 0; m_rise = 0; m_fall = 0;
      m_first_rise = -1; m_last_rise = -1; m_busy = 0; m_done = 0; m_mosi_bits = 8'h00;
      prev = SCK;
      for (int i = 0; i < n; i++) begin
         if (i == inject_at) begin
            if (inject_kind == 1) begin
               start = 1'b1; data_in = 8'h55; cs_sel = 3'd0;
            end else begin
               CPH = ~CPH; CKP = ~CKP; CLK_DIV = 8'd0; LSB_FIRST = ~LSB_FIRST;
            end
         end else begin
            start = 1'b0;
         end
         if (CS[sel] == 1'b0) m_cs_low++;
         if ((CS | (NUM_CS'(1) << sel)) != {NUM_CS{1'b1}}) m_other_low++;
         if (busy) m_busy++;
         if (done) m_done++;
         if (!prev && SCK) begin
            if (m_rise < 8) m_mosi_bits[m_rise] = MOSI;
            if (m_first_rise < 0) m_first_rise = cyc;
            m_last_rise = cyc;
            m_rise++;
         end
         if (prev && !SCK) m_fall++;
         prev = SCK;
         @(negedge CLK);
      end
   endtask

   int   k;
   int   edges;
   int   guard;
   logic prev_sck;

   // Directed stimulus
   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_cs", int'(CS), 'hF);
      check("rst_sck", int'(SCK), 0);
      check("rst_mosi", int'(MOSI), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_data_out", int'(data_out), 0);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      CKP = 1'b1; #1;
      check("idle_sck_follows_ckp", int'(SCK), 1);
      CKP = 1'b0;

      // Mode 0, CLK_DIV=0, 0xA5 loopback on CS[0]
      issue(MODE0[1], MODE0[0], 1'b0, 8'd0, 3'd0, 8'hA5, k);
      sb_q.push_back('{data: 'hA5, cyc: k + 18});
      measure(20, 0, -1, 0);
      check("m0_cs_low", m_cs_low, 18);
      check("m0_other_cs", m_other_low, 0);
      check("m0_rises", m_rise, 8);
      check("m0_falls", m_fall, 8);
      check("m0_rise_span", m_last_rise - m_first_rise, 14);
      check("m0_mosi_bits", int'(m_mosi_bits), 'hA5);
      check("m0_busy_cycles", m_busy, 18);
      check("m0_done_pulses", m_done, 1);

      // Mode 3, CLK_DIV=3, 0x3C loopback on CS[1]
      @(negedge CLK);
      CKP = 1'b1; #1;
      check("m3_idle_high", int'(SCK), 1);
      issue(MODE3[1], MODE3[0], 1'b0, 8'd3, 3'd1, 8'h3C, k);
      sb_q.push_back('{data: 'h3C, cyc: k + 72});
      measure(76, 1, -1, 0);
      check("m3_cs_low", m_cs_low, 72);
      check("m3_rises", m_rise, 8);
      check("m3_falls", m_fall, 8);
      check("m3_rise_span", m_last_rise - m_first_rise, 56);
      check("m3_mosi_bits", int'(m_mosi_bits), 'h3C);
      check("m3_done_pulses", m_done, 1);

      // LSB first, 0x01, MISO tied high
      miso_loop = 1'b0; miso_tie = 1'b1;
      issue(MODE0[1], MODE0[0], 1'b1, 8'd0, 3'd0, 8'h01, k);
      sb_q.push_back('{data: 'hFF, cyc: k + 18});
      measure(20, 0, -1, 0);
      check("lsb_mosi_bits", int'(m_mosi_bits), 'h01);
      check("lsb_rises", m_rise, 8);
      miso_loop = 1'b1; miso_tie = 1'b0;

      // CS[2] with a stray start mid-transfer
      issue(MODE0[1], MODE0[0], 1'b0, 8'd1, 3'd2, 8'h96, k);
      sb_q.push_back('{data: 'h96, cyc: k + 36});
      measure(40, 2, 10, 1);
      check("cs2_low", m_cs_low, 36);
      check("cs2_other_cs", m_other_low, 0);
      check("cs2_done_pulses", m_done, 1);
      check("cs2_idle_after", int'(busy), 0);

      // Out-of-range cs_sel is ignored
      issue(MODE0[1], MODE0[0], 1'b0, 8'd0, 3'd4, 8'h11, k);
      measure(6, 0, -1, 0);
      check("badsel_busy", m_busy, 0);
      check("badsel_cs", m_cs_low + m_other_low, 0);
      check("badsel_done", m_done, 0);
      check("badsel_data_kept", int'(data_out), 'h96);

      // Reset after the 4th SCK edge aborts the transfer
      issue(MODE2[1], MODE2[0], 1'b0, 8'd1, 3'd1, 8'hF3, k);
      prev_sck = SCK; edges = 0; guard = 0;
      while (edges < 4 && guard < 100) begin
         @(negedge CLK);
         if (SCK != prev_sck) edges++;
         prev_sck = SCK;
         guard++;
      end
      check("abort_edges_reached", edges, 4);
      check("abort_mosi_before", int'(MOSI), 1);
      RESET = 1'b0;
      CKP   = 1'b0;
      #1;
      check("abort_cs", int'(CS), 'hF);
      check("abort_sck", int'(SCK), 0);
      check("abort_mosi", int'(MOSI), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_data_out", int'(data_out), 0);
      check("abort_done", int'(done), 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      issue(MODE0[1], MODE0[0], 1'b0, 8'd0, 3'd0, 8'h81, k);
      sb_q.push_back('{data: 'h81, cyc: k + 18});
      measure(20, 0, -1, 0);
      check("post_rst_done_pulses", m_done, 1);

      // Config inputs flipped mid-transfer must not disturb it
      issue(MODE1[1], MODE1[0], 1'b0, 8'd2, 3'd3, 8'h6B, k);
      sb_q.push_back('{data: 'h6B, cyc: k + 54});
      measure(54, 3, 10, 2);
      check("cfg_cs_low", m_cs_low, 54);
      check("cfg_rises", m_rise, 8);
      check("cfg_falls", m_fall, 8);
      check("cfg_rise_span", m_last_rise - m_first_rise, 42);
      check("cfg_mosi_bits", int'(m_mosi_bits), 'hD6);

      // Next start uses the new settings: mode 2, LSB first, CLK_DIV=0
      pulse_start(3'd3, 8'h6B, k);
      sb_q.push_back('{data: 'h6B, cyc: k + 18});
      measure(18, 3, -1, 0);
      check("new_cfg_rises", m_rise, 8);
      check("new_cfg_falls", m_fall, 8);
      check("new_cfg_rise_span", m_last_rise - m_first_rise, 14);
      check("new_cfg_cs_low", m_cs_low, 18);

      repeat (4) @(negedge CLK);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master that succeeds the fixed 8-bit SPI generator. It supports configurable word width, multiple chip selects, all four CKP/CPH modes, MSB- or LSB-first ordering and a programmable SCK divider. A start/busy/done handshake lets a local controller or sequencer issue one full-duplex word transfer at a time. The block sits between that controller and the off-chip SPI pins.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_CS, 4, number of chip-select outputs (>=1)
DIV_W, 8, width of the CLK_DIV configuration input
CS_W, $clog2(NUM_CS) (min 1), width of cs_sel

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-low
CKP  in  1  SCK idle polarity
CPH  in  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST  in  1  1 = shift LSB first
CLK_DIV  in  DIV_W  SCK half-period = CLK_DIV+1 CLK cycles
start  in  1  one-cycle transfer request
cs_sel  in  CS_W  index of the slave to select
data_in  in  DATA_W  word to transmit
MISO  in  1  serial data from slave
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when data_out is valid
CS  out  NUM_CS  chip selects, active-low
SCK  out  1  serial clock
MOSI  out  1  serial data to slave
data_out  out  DATA_W  last received word

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, CS all 1, SCK=CKP (combinational from the live input while idle), MOSI=0, busy=0, done=0, data_out=0, counters 0. Reset mid-transfer aborts immediately; no done pulse.
- Let H = CLK_DIV+1. States:
  - IDLE: SCK=CKP.
  - SETUP (H cycles): CS[cs_sel]=0. With CPH=0, the first data bit is driven on MOSI.
  - XFER (2*DATA_W*H cycles): SCK toggles every H cycles, giving DATA_W leading and DATA_W trailing edges.
  - HOLD (H cycles): SCK=CKP, CS still low.
  - Then return to IDLE: CS high, data_out loaded, done=1 for one cycle.
- start is accepted only in IDLE and only when cs_sel < NUM_CS. The block then samples CKP, CPH, LSB_FIRST, CLK_DIV, cs_sel and data_in into shadow registers; later changes to these inputs have no effect on the transfer in progress. start while busy, or with an invalid cs_sel, is ignored with no side effects.
- Timing: start sampled at CLK edge k sets busy=1 and CS low after edge k. done is high in the cycle following edge k+(2*DATA_W+2)*H, and busy falls on that same edge.
- CPH=0: MISO is sampled on each leading edge; MOSI advances on each trailing edge except the last.
- CPH=1: MOSI advances on each leading edge (first bit driven at the first leading edge); MISO is sampled on each trailing edge.
- Bit order: MSB first unless LSB_FIRST. The received word is assembled in the same order, so a MISO=MOSI loopback returns data_in.
- MOSI holds its last bit through HOLD and returns to 0 in IDLE.
- data_out holds its value until the next completed transfer.
- CLK_DIV at all-ones: the half-period counter is DIV_W+1 bits wide, so it cannot overflow.

Decomposition:
- Package spi_pkg holds:
  - state enum {IDLE, SETUP, XFER, HOLD}
  - mode constants MODE0..MODE3 as {CKP,CPH}
  - helper function clog2_min1.
- Sub-module spi_clk_gen: half-period counter plus SCK toggle. Outputs one-cycle lead_edge and trail_edge strobes and a last_edge flag from an edge counter of width $clog2(2*DATA_W)+1.
- The top level contains the FSM, the shift register and CS decode.

Test Plan:
- Mode 0, CLK_DIV=0, cs_sel=0, data_in=0xA5, MISO looped to MOSI: CS[0] low for 18 cycles; 8 rising SCK edges; done in the cycle following edge k+18; data_out=0xA5; CS[3:1] stay 1.
- Mode 3 (CKP=1, CPH=1), CLK_DIV=3, data_in=0x3C, loopback: SCK idle high with an 8-cycle period; MISO sampled on rising edges; data_out=0x3C; done in the cycle following edge k+72.
- LSB_FIRST=1, data_in=0x01, MISO tied 1: first MOSI bit is 1 and the rest are 0; data_out=0xFF.
- cs_sel=2: only CS[2] goes low. A second start pulsed mid-transfer with data_in=0x55 is ignored: exactly one done pulse, and data_out reflects the first word. A start with cs_sel=4 (NUM_CS=4) is ignored: busy stays 0.
- RESET driven to 0 after the 4th SCK edge: in the same cycle CS=4'hF, SCK=CKP, MOSI=0, busy=0, data_out=0; no done pulse. After release, a fresh transfer with data_in=0x81 returns 0x81.
- Changing CPH, CKP and CLK_DIV mid-transfer does not alter SCK timing or sampled data; the new settings apply to the next start.
